// File: rtl/cv32e40x_obi_sram_responder.sv
// OBI memory responder: single-port word SRAM that answers the core's instruction or data port.
// Latency: rvalid RVALID_LATENCY cycles after the accept edge, always in accept order.
// Backpressure: gnt held low for GNT_STALL cycles per address phase and while MAX_OUTSTANDING are in flight.
module cv32e40x_obi_sram_responder #(
    parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
    parameter int          MEM_WORDS       = 1024,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          GNT_STALL       = 0,
    parameter int          RVALID_LATENCY  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic [5:0]  atop_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        exokay_o
);

    localparam int          IDX_W   = $clog2(MEM_WORDS);
    localparam int          CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [32:0] MEM_END = {1'b0, MEM_BASE} + 33'(4 * MEM_WORDS);

    logic [31:0]      mem [MEM_WORDS];
    logic [3:0]       stall_cnt;
    logic [CNT_W-1:0] outstanding;

    logic             pipe_vld   [RVALID_LATENCY];
    logic             pipe_err   [RVALID_LATENCY];
    logic [31:0]      pipe_rdata [RVALID_LATENCY];

    logic             accept;
    logic             dec_err;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rsp_word;

    // Grant only when the stall window has elapsed and a response slot is free.
    assign gnt_o  = req_i & ~rst_i & (stall_cnt == 4'd0)
                  & (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign accept = req_i & gnt_o;

    // Out-of-window addresses and any atomic opcode are answered with an error.
    assign dec_err  = ({1'b0, addr_i} < {1'b0, MEM_BASE})
                    | ({1'b0, addr_i} >= MEM_END)
                    | (atop_i != 6'd0);
    assign word_idx = IDX_W'((addr_i - MEM_BASE) >> 2);

    // Reads return the word as stored before this edge; writes and errors return zero.
    always_comb begin
        rsp_word = 32'd0;
        if (!we_i && !dec_err) begin
            rsp_word = mem[word_idx];
        end
    end

    // Byte-lane write at the accept edge; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && !dec_err) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Fixed-latency response shift register; idle slots carry zeros so outputs are clean.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RVALID_LATENCY; i++) begin
                pipe_vld[i]   <= 1'b0;
                pipe_err[i]   <= 1'b0;
                pipe_rdata[i] <= 32'd0;
            end
        end else begin
            for (int i = RVALID_LATENCY - 1; i > 0; i--) begin
                pipe_vld[i]   <= pipe_vld[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
            end
            pipe_vld[0]   <= accept;
            pipe_err[0]   <= accept & dec_err;
            pipe_rdata[0] <= accept ? rsp_word : 32'd0;
        end
    end

    assign rvalid_o = pipe_vld[RVALID_LATENCY-1];
    assign err_o    = pipe_err[RVALID_LATENCY-1];
    assign rdata_o  = pipe_rdata[RVALID_LATENCY-1];
    assign exokay_o = 1'b0;

    // Track accepted-but-unanswered transactions.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding <= '0;
        end else if (accept && !rvalid_o) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (!accept && rvalid_o) begin
            outstanding <= outstanding - CNT_W'(1);
        end
    end

    // Grant stall: reload per address phase, count down only while a request waits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= 4'(GNT_STALL);
        end else if (accept) begin
            stall_cnt <= 4'(GNT_STALL);
        end else if (req_i && (stall_cnt != 4'd0)) begin
            stall_cnt <= stall_cnt - 4'd1;
        end
    end

    // Outstanding count must stay within bounds.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (outstanding <= CNT_W'(MAX_OUTSTANDING))
                else $error("outstanding count above limit");
            assert (!(rvalid_o && (outstanding == '0)))
                else $error("outstanding count underflow");
        end
    end

endmodule

// File: doc/cv32e40x_obi_sram_responder.md
Name: cv32e40x_obi_sram_responder

Overview:
- Synthesizable OBI responder, i.e. the memory end of the core's OBI instruction or data port.
- Used in the testbench as a deterministic backing memory behind `obi_instr_if` / `obi_data_if`.
- Accepts address-phase requests with a configurable grant stall and a bounded number of outstanding transactions.
- Returns in-order responses after a fixed latency, with error signalling for unmapped and atomic accesses.

Parameters:
- MEM_BASE, 32'h0000_0000, byte address of word 0.
- MEM_WORDS, 1024, number of 32-bit words; power of two, ≥ 2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions; 1..8.
- GNT_STALL, 0, cycles `gnt_o` is held low at the start of each new address phase; 0..15.
- RVALID_LATENCY, 1, cycles from accept edge to `rvalid_o`; 1..8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  OBI address-phase request.
- gnt_o  out  1  OBI grant.
- addr_i  in  32  byte address.
- we_i  in  1  1 = write.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data.
- atop_i  in  6  atomic opcode; any nonzero value is unsupported.
- rvalid_o  out  1  response valid, one-cycle pulse per transaction.
- rdata_o  out  32  read data; 0 for writes and errors.
- err_o  out  1  response error, qualified by `rvalid_o`.
- exokay_o  out  1  tied 0.

Behaviour:
- Reset:
  - While `rst_i` is high at a clock edge: `gnt_o`, `rvalid_o`, `err_o`, `rdata_o` = 0.
  - Outstanding count = 0, response pipeline flushed, stall counter reloaded with GNT_STALL.
  - Memory contents are NOT reset.
  - `gnt_o` is forced 0 while `rst_i` = 1.
- Reset mid-operation: all queued responses are dropped. No `rvalid_o` is issued for them after reset deasserts.
- Grant:
  - `gnt_o` = `req_i` & !`rst_i` & (stall_cnt == 0) & (outstanding < MAX_OUTSTANDING). Combinational from these inputs and state.
  - Accept = `req_i` & `gnt_o` at a rising edge.
- Stall counter:
  - Loads GNT_STALL on reset and on every accept.
  - Decrements (saturating at 0) each cycle `req_i` = 1 and no accept occurs.
  - Holds while `req_i` = 0.
  - With GNT_STALL = 0, back-to-back accepts every cycle are possible.
- Requester protocol: the requester keeps addr/we/be/wdata/atop stable while `req_i` & !`gnt_o`. The block may sample them only at accept.
- Decode:
  - err = (addr_i < MEM_BASE) | (addr_i ≥ MEM_BASE + 4*MEM_WORDS) | (atop_i != 0).
  - Word index = (addr_i − MEM_BASE) >> 2, low log2(MEM_WORDS) bits. `addr_i[1:0]` is ignored.
- Write (accept, we = 1, !err): each byte lane k with `be_i[k]` = 1 is written at the accept edge. Other lanes are unchanged. Response rdata = 0.
- Read (accept, we = 0, !err):
  - Response rdata = full word as stored before the accept edge (all 32 bits returned regardless of `be_i`).
  - A read accepted the cycle after a write to the same word returns the written data.
- Error: no memory update. Response rdata = 0, err = 1.
- Response pipeline:
  - Shift register of depth RVALID_LATENCY carrying {valid, err, rdata}.
  - An entry inserted at accept edge T appears on `rvalid_o`/`err_o`/`rdata_o` for exactly one cycle, starting RVALID_LATENCY cycles after T.
  - Responses are strictly in accept order. There is no back-pressure.
  - `rdata_o`/`err_o` are 0 whenever `rvalid_o` = 0.
- Outstanding count:
  - +1 on accept, −1 on the cycle `rvalid_o` = 1; unchanged when both occur.
  - Never exceeds MAX_OUTSTANDING and never underflows; both are assertion-checked.
  - When count == MAX_OUTSTANDING and a response is presented in the current cycle, `gnt_o` stays low that cycle. The next grant is possible the following cycle.
- `exokay_o` = 0 always.

Test Plan:
- Reset then idle → `gnt_o`/`rvalid_o` = 0. Pulse `rst_i` 3 cycles with 2 responses queued → no `rvalid_o` after release.
- GNT_STALL = 0, RVALID_LATENCY = 1: write 0xDEADBEEF to 0x10 with be = 4'hF, then read 0x10 on the next cycle → read `rvalid_o` 1 cycle after its accept, `rdata_o` = 0xDEADBEEF, `err_o` = 0.
- Byte enables: word 0x20 = 0x11223344, write be = 4'b0101 wdata = 0xAABBCCDD → read returns 0x11BB33DD.
- GNT_STALL = 3: `req_i` held high → `gnt_o` first high on the 4th cycle of the request. A second back-to-back request is again stalled 3 cycles.
- MAX_OUTSTANDING = 2, RVALID_LATENCY = 4: four continuous read requests → `gnt_o` low after 2 accepts until the first `rvalid_o`. Responses arrive in order, and the count never reaches 3.
- Read 0x0000_1000 with MEM_WORDS = 1024, and write with `atop_i` = 6'h20 → both respond `err_o` = 1, `rdata_o` = 0. A subsequent read of word 0 is unchanged.
